// File: rtl/ultra_pkg.sv
// ultra_pkg: shared ASCII constants, default baud divisor, FSM states and digit-select helper
package ultra_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;
  function automatic logic [2:0] first_sig(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return a != ASCII_ZERO ? 3'd0 : b != ASCII_ZERO ? 3'd1 : c != ASCII_ZERO ? 3'd2 : 3'd3;
  endfunction
endpackage

// File: rtl/dist_uart_framer_if.sv
// dist_uart_framer_if: digit/load request bundle and tx/busy/done status of the framer
interface dist_uart_framer_if;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic [7:0] d4;
  logic load;
  logic tx;
  logic busy;
  logic done;
  modport master (output d1, d2, d3, d4, load, input tx, busy, done);
  modport slave (input d1, d2, d3, d4, load, output tx, busy, done);
endinterface

// File: rtl/dist_uart_framer_tx.sv
// uart_byte_tx: 8N1 byte serialiser; start+data in, tx/ready/last (final stop cycle) out
module uart_byte_tx import ultra_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       last
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic tick, take;
  assign tick = cnt == TOP;
  assign ready = st == IDLE;
  assign last = st == STOP && tick;
  assign take = start && (st == IDLE || last);
  assign tx = st == START ? 1'b0 : st == DATA ? sh[0] : 1'b1;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = start ? START : IDLE;
      START: nxt = tick ? DATA : START;
      DATA: nxt = tick && bitn == 3'd7 ? STOP : DATA;
      STOP: nxt = tick ? NEXT : STOP;
      default: nxt = IDLE;
    endcase
    if (nxt == NEXT) nxt = start ? START : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
    end else begin
      st <= nxt;
      cnt <= st == IDLE || tick ? '0 : cnt + 1'b1;
      bitn <= st == START ? 3'd0 : st == DATA && tick && bitn != 3'd7 ? bitn + 3'd1 : bitn;
      sh <= take ? data : st == DATA && tick ? sh >> 1 : sh;
    end
  end
endmodule

// File: rtl/dist_uart_framer.sv
// dist_uart_framer: sends ASCII distance d1..d4 (leading zeros suppressed, optional CR/LF) over 8N1 UART
module dist_uart_framer import ultra_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SEND_CRLF = 1
) (
  input logic clk,
  input logic rst_n,
  dist_uart_framer_if.slave bus
);
  localparam logic [2:0] LAST_IDX = SEND_CRLF != 0 ? 3'd5 : 3'd3;
  logic [7:0] s1, s2, s3, s4, cur;
  logic [2:0] idx, nidx;
  logic pend, ready, last, more, start, accept;
  assign more = idx != LAST_IDX;
  assign nidx = last && more ? idx + 3'd1 : idx;
  assign cur = nidx == 3'd0 ? s1 : nidx == 3'd1 ? s2 : nidx == 3'd2 ? s3 :
               nidx == 3'd3 ? s4 : nidx == 3'd4 ? ASCII_CR : ASCII_LF;
  assign start = pend || (last && more);
  assign accept = bus.load && ready && !pend;
  assign bus.busy = !ready;
  assign bus.done = last && !more;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      idx <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else begin
      pend <= accept;
      idx <= accept ? first_sig(bus.d1, bus.d2, bus.d3) : nidx;
      s1 <= accept ? bus.d1 : s1;
      s2 <= accept ? bus.d2 : s2;
      s3 <= accept ? bus.d3 : s3;
      s4 <= accept ? bus.d4 : s4;
    end
  end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data(cur),
    .tx(bus.tx),
    .ready(ready),
    .last(last)
  );
endmodule

// File: tb/tb_dist_uart_framer.sv
// tb_dist_uart_framer: table-driven frames with UART decoding scoreboard plus reset/mid-frame/done-cycle corner cases
module tb_dist_uart_framer;
  typedef struct {
    logic [7:0] d1, d2, d3, d4;
    int n;
    logic [0:5][7:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[8];
  dist_uart_framer_if bus();
  dist_uart_framer #(.CLKS_PER_BIT(4), .SEND_CRLF(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [7:0] a, b, c, d, input int n, input logic [0:5][7:0] e);
    vec_t v;
    v.d1 = a; v.d2 = b; v.d3 = c; v.d4 = d; v.n = n; v.e = e;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic run_frame(input vec_t v, input int inj_mid, input bit inj_done);
    int cyc, dn, ph;
    bit in_b, last_done, got_end, idle_ok;
    logic [7:0] b;
    logic sb;
    cyc = 0; dn = 0; ph = 0; in_b = 0; last_done = 0; got_end = 0; idle_ok = 1; b = '0; sb = 1'b1;
    @(negedge clk);
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.e[i]);
    bus.d1 = v.d1; bus.d2 = v.d2; bus.d3 = v.d3; bus.d4 = v.d4; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("busy_after_accept_edge", bus.busy, 1'b0);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (t == 0) begin
        chk("first_cycle_busy", bus.busy, 1'b1);
        chk("first_cycle_tx", bus.tx, 1'b0);
      end
      if (!bus.busy) begin
        got_end = 1;
        break;
      end
      cyc++;
      if (bus.done) dn++;
      last_done = bus.done;
      if (!in_b) begin
        if (bus.tx == 1'b0) begin
          in_b = 1; ph = 0;
        end
      end else ph++;
      if (in_b) begin
        if (ph == 2) sb = bus.tx;
        if (ph >= 6 && ph <= 34 && (ph - 2) % 4 == 0) b[(ph - 6) / 4] = bus.tx;
        if (ph == 38) begin
          chk("start_bit", sb, 1'b0);
          chk("stop_bit", bus.tx, 1'b1);
          if (exp_q.size() == 0) chk("unexpected_byte", b, 9'h100);
          else chk("byte", b, exp_q.pop_front());
          in_b = 0;
        end
      end
      if (inj_mid != 0 && cyc == inj_mid) begin
        bus.load = 1'b1;
        bus.d1 = "9"; bus.d2 = "8"; bus.d3 = "7"; bus.d4 = "6";
      end
      if (inj_mid != 0 && cyc > inj_mid) begin
        bus.d1 = 8'h30 + 8'(cyc % 10); bus.d4 = 8'h5A;
      end
      if (inj_done && bus.done) bus.load = 1'b1;
    end
    bus.load = 1'b0;
    chk("frame_ended", got_end, 1'b1);
    chk("busy_cycles", cyc, v.n * 40);
    chk("done_pulses", dn, 1);
    chk("done_on_last_cycle", last_done, 1'b1);
    chk("bytes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1 || bus.done !== 1'b0) idle_ok = 0;
    end
    chk("idle_after_frame", idle_ok, 1'b1);
  endtask
  initial begin
    bus.load = 1'b0; bus.d1 = 8'h30; bus.d2 = 8'h30; bus.d3 = 8'h30; bus.d4 = 8'h30;
    vecs[0] = mk("0", "1", "2", "3", 5, {8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00});
    vecs[1] = mk("0", "0", "0", "0", 3, {8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00});
    vecs[2] = mk("1", "0", "0", "7", 6, {8'h31, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A});
    vecs[3] = mk("0", "0", "4", "2", 4, {8'h34, 8'h32, 8'h0D, 8'h0A, 8'h00, 8'h00});
    vecs[4] = mk("0", "5", "0", "0", 5, {8'h35, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00});
    vecs[5] = mk(" ", "0", "0", "0", 6, {8'h20, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A});
    vecs[6] = mk("0", "0", "A", "0", 4, {8'h41, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00});
    vecs[7] = mk("0", "0", "0", "9", 3, {8'h39, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    chk("reset_tx", bus.tx, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", bus.busy, 1'b0);
    foreach (vecs[i]) run_frame(vecs[i], 0, 0);
    run_frame(vecs[2], 50, 0);
    run_frame(vecs[0], 0, 1);
    @(negedge clk);
    bus.d1 = "5"; bus.d2 = "5"; bus.d3 = "5"; bus.d4 = "5"; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", bus.tx, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_tx", bus.tx, 1'b1);
    run_frame(vecs[3], 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
